digit_serial_add_ctrl: RTL and testbench



---
 rtl/digit_serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_digit_serial_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_add_ctrl
// Description : WIDTH-bit adder built from one time-shared 4-bit carry-lookahead
//               slice, one nibble per cycle, LSB first, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NDIG  = WIDTH / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    logic [3:0] slice_a, slice_b, slice_g, slice_p, slice_s;
    logic [4:0] slice_c;

    // Shared 4-bit carry-lookahead slice, fed by the nibble selected by idx_q.
    always_comb begin
        slice_a    = 4'(a_q >> {idx_q, 2'b00});
        slice_b    = 4'(b_q >> {idx_q, 2'b00});
        slice_g    = slice_a & slice_b;
        slice_p    = slice_a ^ slice_b;
        slice_c[0] = carry_q;
        slice_c[1] = slice_g[0] | (slice_p[0] & slice_c[0]);
        slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & slice_c[0]);
        slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
        slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
        slice_s    = slice_p ^ slice_c[3:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = slice_s;
                    end
                end
                carry_d = slice_c[4];
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_c[4];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_add_ctrl.sv
`default_nettype none
// Self-checking bench for digit_serial_add_ctrl: directed cases plus randomized
// operations against an arithmetic reference, with a WIDTH=4 instance alongside.
module tb_digit_serial_add_ctrl;

    localparam int W    = 16;
    localparam int NDIG = W / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, out_ready, cin;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;

    logic         n_in_valid, n_out_ready, n_cin;
    logic [3:0]   n_a, n_b;
    logic         n_in_ready, n_out_valid, n_cout, n_busy;
    logic [3:0]   n_sum;

    digit_serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    digit_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .sum(n_sum), .cout(n_cout), .busy(n_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 16-bit operation: offer, verify latency/result, hold DONE for `hold` cycles.
    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                          input int hold, output int acc_cycle);
        logic [16:0] expv;
        int n;
        expv = {1'b0, oa} + {1'b0, ob} + 17'(oc);
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check_val("ready_wait", 64'(n < 50), 64'd1);
        in_valid = 1'b1;
        a = oa; b = ob; cin = oc;
        step();
        acc_cycle = cycle;
        in_valid = 1'(($urandom_range(0, 1)));
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            check_val("run_busy_ready", {busy, in_ready}, 2'b10);
            step();
            n++;
        end
        check_val("latency", n, NDIG);
        check_val("sum", sum, expv[15:0]);
        check_val("cout", cout, expv[16]);
        check_val("done_busy_ready", {busy, in_ready}, 2'b10);
        if (hold > 0) out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            step();
            check_val("bp_valid_ready", {out_valid, in_ready}, 2'b10);
            check_val("bp_sum", sum, expv[15:0]);
            check_val("bp_cout", cout, expv[16]);
        end
        out_ready = 1'b1;
        step();
        check_val("after_hs", {out_valid, in_ready, busy}, 3'b010);
        in_valid = 1'b0;
    endtask

    task automatic run_op4(input logic [3:0] oa, input logic [3:0] ob, input logic oc);
        logic [4:0] expv;
        expv = {1'b0, oa} + {1'b0, ob} + 5'(oc);
        check_val("w4_ready", n_in_ready, 1'b1);
        n_in_valid = 1'b1;
        n_a = oa; n_b = ob; n_cin = oc;
        step();
        n_in_valid = 1'b0;
        n_a = 4'($urandom); n_b = 4'($urandom);
        check_val("w4_run", {n_out_valid, n_busy}, 2'b01);
        step();
        check_val("w4_valid", n_out_valid, 1'b1);
        check_val("w4_sum", n_sum, expv[3:0]);
        check_val("w4_cout", n_cout, expv[4]);
        step();
        check_val("w4_idle", {n_out_valid, n_in_ready}, 2'b01);
    endtask

    initial begin
        int t0, t1, t2, t3;
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; a = '0; b = '0;
        n_in_valid = 1'b0; n_out_ready = 1'b1; n_cin = 1'b0; n_a = '0; n_b = '0;
        #1;
        check_val("rst_ctrl", {in_ready, out_valid, busy, cout}, 4'b1000);
        check_val("rst_sum", sum, 16'h0);
        check_val("rst4_ctrl", {n_in_ready, n_out_valid, n_busy, n_cout, n_sum}, 8'b1000_0000);
        step(); step();
        rst_n = 1'b1;
        step();

        run_op(16'h1234, 16'h4321, 1'b0, 0, t0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, t0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, t0);

        // Backpressure, then the following accept must come one cycle after release.
        run_op(16'h8000, 16'h8000, 1'b0, 5, t0);
        run_op(16'h0102, 16'h0304, 1'b0, 0, t1);
        check_val("bp_accept_gap", t1 - t0, NDIG + 2 + 5);

        run_op(16'h0001, 16'h0002, 1'b0, 0, t1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, t2);
        run_op(16'hABCD, 16'h5432, 1'b0, 0, t3);
        check_val("b2b_gap1", t2 - t1, NDIG + 2);
        check_val("b2b_gap2", t3 - t2, NDIG + 2);

        // Reset in the middle of RUN after two nibbles are written.
        in_valid = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_ctrl", {in_ready, out_valid, busy, cout}, 4'b1000);
        check_val("midrst_sum", sum, 16'h0);
        step();
        #3 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid || busy) seen++;
        end
        check_val("midrst_no_valid", seen, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, t0);

        run_op4(4'h9, 4'h8, 1'b1);
        run_op4(4'hF, 4'h0, 1'b1);
        run_op4(4'h3, 4'h4, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), t0);
            run_op4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
